program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits directly upstream of the instruction memory. It takes a byte stream from the UART receiver, assembles bytes into big-endian instruction words, and drives the instruction memory's write port (`inst_in`, `we`) while sequencing its program counter through `stall` and `reset_pc`. After the last word is written it rewinds the PC to 0 and releases the core to run.

## Interface
Parameters (global values from common.vh):
- INST_WIDTH, 32, instruction word width; must be a multiple of 8; BYTES = INST_WIDTH/8
- INST_MEM_WIDTH, 12, instruction memory address width; capacity DEPTH = 2**INST_MEM_WIDTH words

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe: rx_data is valid; may be high on consecutive cycles
- inst_in  out  INST_WIDTH  word to write; goes to the instruction memory's inst_in
- we  out  1  instruction memory write enable
- load_stall  out  1  ORed into the instruction memory's stall; holds the PC
- reset_pc  out  1  instruction memory reset_pc
- done  out  1  program loaded; core running
- err  out  1  header word count exceeded DEPTH

## Operation
- States: HEADER, LOAD, REWIND, RUN, ERR. Reset enters HEADER.
- HEADER:
  - Accepts 4 bytes forming a 32-bit big-endian word count N; the first byte is the MSB.
  - reset_pc=1 and load_stall=1 throughout, so the PC is held at 0.
  - On the 4th byte: N=0 goes to REWIND; N>DEPTH goes to ERR; otherwise goes to LOAD with word counter = 0.
- LOAD:
  - Bytes shift into an INST_WIDTH shift register, MSB first, with a byte index 0..BYTES-1.
  - When byte BYTES-1 is accepted, the assembled word is registered to inst_in, a one-cycle write is issued, the byte index returns to 0 and the word counter increments.
  - When the word counter reaches N, the state goes to REWIND after that word's write.
- Write cycle: we=1 and load_stall=0 for exactly one cycle. The memory stores inst_in at the PC and the PC increments. In every other LOAD cycle load_stall=1 and we=0.
- A byte accepted during a write cycle is handled normally; the shift register is independent of inst_in.
- REWIND: lasts one cycle; reset_pc=1, load_stall=1, we=0. Then RUN.
- RUN: done=1, load_stall=0, reset_pc=0, we=0. rx_valid is ignored. Stays in RUN until reset.
- ERR: err=1, load_stall=1, we=0, reset_pc=0. rx_valid is ignored. Stays in ERR until reset.
- Reset mid-load returns to HEADER; all counters clear; reset_pc=1 again. Words already written stay in memory and are overwritten by the next load.
- Word counter width is INST_MEM_WIDTH+1, so N=DEPTH is legal. The PC wraps to 0 after the final write, and REWIND sets it to 0 anyway.

## Timing
- Reset values: inst_in=0, we=0, load_stall=1, reset_pc=1, done=0, err=0.
- All outputs are registered.
- Byte latency: last byte of a word accepted at edge t → we=1 with inst_in valid in cycle t+1. The memory write and PC increment occur at edge t+2.
- After the last word: its write cycle is t+1; reset_pc=1 in cycle t+2 (REWIND); done=1 and load_stall=0 from cycle t+3.
- N=0: the 4th header byte is accepted at edge t; REWIND is cycle t+1; done=1 from t+2.
- HEADER→ERR: err=1 from the cycle after the 4th header byte.
- Maximum input rate is one byte per cycle with no byte loss. In that case writes occur every BYTES cycles.

## Test plan
- Header 00 00 00 02, then bytes 12 34 56 78 9A BC DE F0 spaced 10 cycles apart → two we pulses with inst_in 0x12345678 and 0x9ABCDEF0 at PC 0 and 1, one reset_pc pulse, then done=1 and load_stall=0.
- Same stream on back-to-back cycles → identical writes; we pulses exactly 4 cycles apart; no byte dropped.
- Header 00 00 00 00 → no we; reset_pc pulse one cycle after the 4th byte; done=1 the cycle after that.
- Header 00 00 10 01 (DEPTH+1 with INST_MEM_WIDTH=12) → err=1, load_stall stays 1, no we, further bytes ignored.
- Assert reset after 6 of 8 payload bytes → outputs return to reset values. A fresh header plus one word then loads correctly, with its write at PC 0.
- Bytes sent after done=1 → no we, no reset_pc, and done stays 1.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: assembles UART bytes into big-endian instruction words and
// writes them into instruction memory, then rewinds the PC and releases the core.
module program_loader #(
  parameter int INST_WIDTH     = 32,
  parameter int INST_MEM_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [INST_WIDTH-1:0] inst_in,
  output logic                  we,
  output logic                  load_stall,
  output logic                  reset_pc,
  output logic                  done,
  output logic                  err
);

  localparam int          BYTES = INST_WIDTH / 8;
  localparam int          BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int          CW    = INST_MEM_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'(2 ** INST_MEM_WIDTH);

  typedef enum logic [2:0] {
    S_HEADER,
    S_LOAD,
    S_REWIND,
    S_RUN,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [23:0]           hdr_q, hdr_d;
  logic [1:0]            hdr_idx_q, hdr_idx_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [BIW-1:0]        byte_idx_q, byte_idx_d;
  logic [INST_WIDTH-1:0] shift_q, shift_d;
  logic                  last_q, last_d;
  logic [INST_WIDTH-1:0] inst_in_q, inst_in_d;
  logic                  we_q, we_d;
  logic                  load_stall_q, load_stall_d;
  logic                  reset_pc_q, reset_pc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           hdr_word;
  logic [INST_WIDTH-1:0] shift_next;

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    hdr_idx_d  = hdr_idx_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    inst_in_d  = inst_in_q;
    we_d       = 1'b0;
    hdr_word   = {hdr_q, rx_data};
    shift_next = (shift_q << 8) | INST_WIDTH'(rx_data);

    case (state_q)
      S_HEADER: begin
        if (rx_valid) begin
          hdr_d     = hdr_word[23:0];
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            if (hdr_word == 32'd0) begin
              state_d = S_REWIND;
            end else if (hdr_word > DEPTH) begin
              state_d = S_ERR;
            end else begin
              state_d    = S_LOAD;
              n_d        = CW'(hdr_word);
              word_cnt_d = '0;
              byte_idx_d = '0;
              last_d     = 1'b0;
            end
          end
        end
      end
      S_LOAD: begin
        // The final word's write cycle must finish before rewinding the PC.
        if (last_q) begin
          state_d = S_REWIND;
        end else if (rx_valid) begin
          shift_d = shift_next;
          if (byte_idx_q == BIW'(BYTES - 1)) begin
            inst_in_d  = shift_next;
            we_d       = 1'b1;
            byte_idx_d = '0;
            word_cnt_d = word_cnt_q + CW'(1);
            if (word_cnt_q + CW'(1) == n_q) begin
              last_d = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + BIW'(1);
          end
        end
      end
      S_REWIND: state_d = S_RUN;
      default:  state_d = state_q;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    load_stall_d = (state_d != S_RUN) && !we_d;
    reset_pc_d   = (state_d == S_HEADER) || (state_d == S_REWIND);
    done_d       = (state_d == S_RUN);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HEADER;
      hdr_q        <= '0;
      hdr_idx_q    <= '0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      inst_in_q    <= '0;
      we_q         <= 1'b0;
      load_stall_q <= 1'b1;
      reset_pc_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      hdr_idx_q    <= hdr_idx_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      inst_in_q    <= inst_in_d;
      we_q         <= we_d;
      load_stall_q <= load_stall_d;
      reset_pc_q   <= reset_pc_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign inst_in    = inst_in_q;
  assign we         = we_q;
  assign load_stall = load_stall_q;
  assign reset_pc   = reset_pc_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a small instruction
// memory PC model that records every write with its address and cycle.
module tb_program_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  rxData;
   logic        rxValid;
   logic [31:0] instIn;
   logic        we;
   logic        loadStall;
   logic        resetPc;
   logic        done;
   logic        err;

   int compareCount = 0;
   int mismatchCount = 0;

   int cycleCount = 0;
   int pcModel = 0;
   int lastSendCycle = 0;
   int resetPcRises = 0;
   int lastResetPcRise = -1;
   int doneRiseCycle = -1;
   logic prevResetPc = 1'b1;
   logic prevDone = 1'b0;

   logic [31:0] weData[$];
   int          weAddr[$];
   int          weCycle[$];

   logic [7:0] payload [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
   logic [7:0] word2 [4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};

   int base;
   int riseBase;
   int firstWordSend;

   program_loader #(.INST_WIDTH(32), .INST_MEM_WIDTH(12)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rxData),
      .rx_valid  (rxValid),
      .inst_in   (instIn),
      .we        (we),
      .load_stall(loadStall),
      .reset_pc  (resetPc),
      .done      (done),
      .err       (err)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter and the instruction memory's program counter.
   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
      if (resetPc) pcModel <= 0;
      else if (!loadStall) pcModel <= pcModel + 1;
   end

   // Log writes and output edges away from the active clock edge.
   always @(negedge clk) begin
      if (we) begin
         weData.push_back(instIn);
         weAddr.push_back(pcModel);
         weCycle.push_back(cycleCount);
      end
      if (resetPc && !prevResetPc) begin
         resetPcRises++;
         lastResetPcRise = cycleCount;
      end
      prevResetPc = resetPc;
      if (done && !prevDone) doneRiseCycle = cycleCount;
      prevDone = done;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one byte for one cycle, then idles for gap cycles; entered at a negedge.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      rxData = b;
      rxValid = 1'b1;
      lastSendCycle = cycleCount;
      @(negedge clk);
      rxValid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic sendHeader(input logic [31:0] n);
      for (int i = 0; i < 4; i++) applyStimulus(n[31 - 8 * i -: 8], 0);
   endtask

   task automatic applyReset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      rxValid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput({tag, " inst_in"}, instIn, 32'h0);
      checkOutput({tag, " we"}, {31'b0, we}, 32'h0);
      checkOutput({tag, " load_stall"}, {31'b0, loadStall}, 32'h1);
      checkOutput({tag, " reset_pc"}, {31'b0, resetPc}, 32'h1);
      checkOutput({tag, " done"}, {31'b0, done}, 32'h0);
      checkOutput({tag, " err"}, {31'b0, err}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      rxValid = 1'b0;
      rxData = 8'h00;

      $display("[TB] reset values");
      applyReset("rst0");

      $display("[TB] two words spaced 10 cycles apart");
      base = weData.size();
      riseBase = resetPcRises;
      sendHeader(32'd2);
      for (int i = 0; i < 8; i++) applyStimulus(payload[i], 9);
      checkOutput("slow wcount", 32'(weData.size() - base), 32'd2);
      checkOutput("slow w0 data", weData[base], 32'h12345678);
      checkOutput("slow w1 data", weData[base + 1], 32'h9ABCDEF0);
      checkOutput("slow w0 addr", 32'(weAddr[base]), 32'd0);
      checkOutput("slow w1 addr", 32'(weAddr[base + 1]), 32'd1);
      checkOutput("slow w1 latency", 32'(weCycle[base + 1]), 32'(lastSendCycle + 1));
      checkOutput("slow rpc rises", 32'(resetPcRises - riseBase), 32'd1);
      checkOutput("slow rpc cycle", 32'(lastResetPcRise), 32'(lastSendCycle + 2));
      checkOutput("slow done cycle", 32'(doneRiseCycle), 32'(lastSendCycle + 3));
      checkOutput("slow done", {31'b0, done}, 32'h1);
      checkOutput("slow load_stall", {31'b0, loadStall}, 32'h0);
      checkOutput("slow reset_pc", {31'b0, resetPc}, 32'h0);

      $display("[TB] bytes after done");
      base = weData.size();
      riseBase = resetPcRises;
      for (int i = 0; i < 4; i++) applyStimulus(payload[i], 2);
      checkOutput("post wcount", 32'(weData.size() - base), 32'd0);
      checkOutput("post rpc rises", 32'(resetPcRises - riseBase), 32'd0);
      checkOutput("post done", {31'b0, done}, 32'h1);

      $display("[TB] back-to-back stream");
      applyReset("rst1");
      base = weData.size();
      sendHeader(32'd2);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(payload[i], 0);
         if (i == 3) firstWordSend = lastSendCycle;
      end
      repeat (6) @(negedge clk);
      checkOutput("fast wcount", 32'(weData.size() - base), 32'd2);
      checkOutput("fast w0 data", weData[base], 32'h12345678);
      checkOutput("fast w1 data", weData[base + 1], 32'h9ABCDEF0);
      checkOutput("fast w1 addr", 32'(weAddr[base + 1]), 32'd1);
      checkOutput("fast w0 latency", 32'(weCycle[base]), 32'(firstWordSend + 1));
      checkOutput("fast spacing", 32'(weCycle[base + 1] - weCycle[base]), 32'd4);
      checkOutput("fast done", {31'b0, done}, 32'h1);

      $display("[TB] zero-length program");
      applyReset("rst2");
      base = weData.size();
      sendHeader(32'd0);
      checkOutput("n0 rewind reset_pc", {31'b0, resetPc}, 32'h1);
      checkOutput("n0 rewind done", {31'b0, done}, 32'h0);
      @(negedge clk);
      checkOutput("n0 run done", {31'b0, done}, 32'h1);
      checkOutput("n0 run reset_pc", {31'b0, resetPc}, 32'h0);
      checkOutput("n0 run load_stall", {31'b0, loadStall}, 32'h0);
      checkOutput("n0 wcount", 32'(weData.size() - base), 32'd0);

      $display("[TB] oversize header");
      applyReset("rst3");
      base = weData.size();
      sendHeader(32'h0000_1001);
      checkOutput("err flag", {31'b0, err}, 32'h1);
      checkOutput("err load_stall", {31'b0, loadStall}, 32'h1);
      for (int i = 0; i < 8; i++) applyStimulus(payload[i], 0);
      repeat (3) @(negedge clk);
      checkOutput("err wcount", 32'(weData.size() - base), 32'd0);
      checkOutput("err sticky", {31'b0, err}, 32'h1);
      checkOutput("err done", {31'b0, done}, 32'h0);
      checkOutput("err reset_pc", {31'b0, resetPc}, 32'h0);

      $display("[TB] header equal to depth");
      applyReset("rst4");
      sendHeader(32'h0000_1000);
      checkOutput("depth err", {31'b0, err}, 32'h0);
      checkOutput("depth reset_pc", {31'b0, resetPc}, 32'h0);
      checkOutput("depth load_stall", {31'b0, loadStall}, 32'h1);

      $display("[TB] reset mid-load then reload");
      applyReset("rst5");
      base = weData.size();
      sendHeader(32'd2);
      for (int i = 0; i < 6; i++) applyStimulus(payload[i], 0);
      checkOutput("mid wcount", 32'(weData.size() - base), 32'd1);
      applyReset("rst6");
      base = weData.size();
      sendHeader(32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(word2[i], 0);
      repeat (4) @(negedge clk);
      checkOutput("reload wcount", 32'(weData.size() - base), 32'd1);
      checkOutput("reload data", weData[base], 32'hCAFEBABE);
      checkOutput("reload addr", 32'(weAddr[base]), 32'd0);
      checkOutput("reload done", {31'b0, done}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
